// File: rtl/iq_pack_pkg.sv
// Shared constants and helpers for the IQ sample packer: lane math, parameter
// legality and the shift/round step of the quantiser.
package iq_pack_pkg;

    localparam int unsigned IQ_W    = 16;
    localparam int unsigned SHIFT_W = 4;

    function automatic int unsigned spw(input int unsigned bits, input int unsigned out_width);
        return out_width / (2 * bits);
    endfunction

    function automatic bit bits_legal(input int unsigned bits, input int unsigned out_width);
        return (bits == 1 || bits == 2 || bits == 4 || bits == 8) &&
               (out_width >= 2 * bits) && ((out_width % (2 * bits)) == 0);
    endfunction

    // Optional half-up rounding then arithmetic shift; 17 bits so x + 2^14 cannot wrap.
    function automatic logic signed [IQ_W:0] shift_round(input logic signed [IQ_W-1:0] x,
                                                         input logic [SHIFT_W-1:0]  shift,
                                                         input logic                rnd);
        logic signed [IQ_W:0] t;
        t = {x[IQ_W-1], x};
        if (rnd && (shift != '0)) begin
            t = t + ((IQ_W + 1)'(1) << (shift - SHIFT_W'(1)));
        end
        return t >>> shift;
    endfunction

endpackage

// File: rtl/iq_quantizer.sv
// Combinational quantiser for one 16-bit component: shift/round, then clamp
// to a BITS-bit signed range with a saturation flag.
module iq_quantizer
    import iq_pack_pkg::*;
#(
    parameter int unsigned BITS = 4
) (
    input  logic signed [IQ_W-1:0]    x,
    input  logic        [SHIFT_W-1:0] cfg_shift,
    input  logic                      cfg_round,
    output logic        [BITS-1:0]    y,
    output logic                      sat
);

    localparam int                   QMAX_I = (1 << (BITS - 1)) - 1;
    localparam logic signed [IQ_W:0] QMAX   = QMAX_I[IQ_W:0];
    localparam logic signed [IQ_W:0] QMIN   = ~QMAX;

    logic signed [IQ_W:0] t;

    always_comb begin
        t   = shift_round(x, cfg_shift, cfg_round);
        y   = t[BITS-1:0];
        sat = 1'b0;
        if (t > QMAX) begin
            y   = QMAX[BITS-1:0];
            sat = 1'b1;
        end else if (t < QMIN) begin
            y   = QMIN[BITS-1:0];
            sat = 1'b1;
        end
    end

endmodule

// File: rtl/iq_sample_packer.sv
// Quantises 16-bit IQ samples to BITS bits per component and packs SPW samples
// per output word, flushing partial words on tlast.
module iq_sample_packer
    import iq_pack_pkg::*;
#(
    parameter  int unsigned BITS      = 4,
    parameter  int unsigned OUT_WIDTH = 32,
    parameter  int unsigned SAT_CNT_W = 16,
    localparam int unsigned SPW       = spw(BITS, OUT_WIDTH),
    localparam int unsigned NS_W      = $clog2(SPW + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [SHIFT_W-1:0]   cfg_shift,
    input  logic                 cfg_round,
    input  logic                 sat_clr,
    output logic [SAT_CNT_W-1:0] sat_cnt,
    input  logic [31:0]          i_tdata,
    input  logic                 i_tlast,
    input  logic                 i_tvalid,
    output logic                 i_tready,
    output logic [OUT_WIDTH-1:0] o_tdata,
    output logic                 o_tlast,
    output logic [NS_W-1:0]      o_nsamps,
    output logic                 o_tvalid,
    input  logic                 o_tready
);

    localparam int unsigned            LANE_W    = (SPW > 1) ? $clog2(SPW) : 1;
    localparam logic [LANE_W-1:0]      LANE_LAST = LANE_W'(SPW - 1);

    if (!bits_legal(BITS, OUT_WIDTH)) begin : g_param_check
        $error("iq_sample_packer: illegal BITS/OUT_WIDTH combination");
    end

    logic [BITS-1:0]      y_i, y_q;
    logic                 sat_i, sat_q;
    logic                 accept, complete;
    logic [2*BITS-1:0]    lane_val;
    logic [OUT_WIDTH-1:0] acc_new;
    logic [1:0]           sat_inc;
    logic [SAT_CNT_W:0]   sat_sum;

    logic [LANE_W-1:0]    lane_cnt_q, lane_cnt_d;
    logic [OUT_WIDTH-1:0] acc_q, acc_d;
    logic [OUT_WIDTH-1:0] o_tdata_q, o_tdata_d;
    logic                 o_tlast_q, o_tlast_d;
    logic [NS_W-1:0]      o_nsamps_q, o_nsamps_d;
    logic                 o_tvalid_q, o_tvalid_d;
    logic [SAT_CNT_W-1:0] sat_cnt_q, sat_cnt_d;

    iq_quantizer #(.BITS(BITS)) u_quant_i (
        .x         (i_tdata[31:16]),
        .cfg_shift (cfg_shift),
        .cfg_round (cfg_round),
        .y         (y_i),
        .sat       (sat_i)
    );

    iq_quantizer #(.BITS(BITS)) u_quant_q (
        .x         (i_tdata[15:0]),
        .cfg_shift (cfg_shift),
        .cfg_round (cfg_round),
        .y         (y_q),
        .sat       (sat_q)
    );

    // Output register drains and refills in the same cycle, so ready bypasses on o_tready.
    assign i_tready = ~o_tvalid_q | o_tready;
    assign accept   = i_tvalid & i_tready;
    assign complete = accept & ((lane_cnt_q == LANE_LAST) | i_tlast);
    assign lane_val = {y_i, y_q};

    always_comb begin
        acc_new = acc_q;
        for (int unsigned k = 0; k < SPW; k++) begin
            if (LANE_W'(k) == lane_cnt_q) begin
                acc_new[OUT_WIDTH-1-k*2*BITS -: 2*BITS] = lane_val;
            end
        end
    end

    always_comb begin
        lane_cnt_d = lane_cnt_q;
        acc_d      = acc_q;
        o_tdata_d  = o_tdata_q;
        o_tlast_d  = o_tlast_q;
        o_nsamps_d = o_nsamps_q;
        o_tvalid_d = o_tvalid_q & ~o_tready;
        if (complete) begin
            lane_cnt_d = '0;
            acc_d      = '0;
            o_tdata_d  = acc_new;
            o_tlast_d  = i_tlast;
            o_nsamps_d = NS_W'(lane_cnt_q) + NS_W'(1);
            o_tvalid_d = 1'b1;
        end else if (accept) begin
            lane_cnt_d = lane_cnt_q + LANE_W'(1);
            acc_d      = acc_new;
        end
    end

    always_comb begin
        sat_inc = accept ? ({1'b0, sat_i} + {1'b0, sat_q}) : 2'd0;
        sat_sum = {1'b0, sat_cnt_q} + (SAT_CNT_W + 1)'(sat_inc);
        if (sat_clr) begin
            sat_cnt_d = '0;
        end else if (sat_sum[SAT_CNT_W]) begin
            sat_cnt_d = '1;
        end else begin
            sat_cnt_d = sat_sum[SAT_CNT_W-1:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lane_cnt_q <= '0;
            acc_q      <= '0;
            o_tdata_q  <= '0;
            o_tlast_q  <= 1'b0;
            o_nsamps_q <= '0;
            o_tvalid_q <= 1'b0;
            sat_cnt_q  <= '0;
        end else begin
            lane_cnt_q <= lane_cnt_d;
            acc_q      <= acc_d;
            o_tdata_q  <= o_tdata_d;
            o_tlast_q  <= o_tlast_d;
            o_nsamps_q <= o_nsamps_d;
            o_tvalid_q <= o_tvalid_d;
            sat_cnt_q  <= sat_cnt_d;
        end
    end

    assign o_tdata  = o_tdata_q;
    assign o_tlast  = o_tlast_q;
    assign o_nsamps = o_nsamps_q;
    assign o_tvalid = o_tvalid_q;
    assign sat_cnt  = sat_cnt_q;

endmodule

// File: tb/tb_iq_sample_packer.sv
// Scoreboard bench for iq_sample_packer: directed cases plus a randomized run
// against an arithmetic reference model with random output backpressure.
module tb_iq_sample_packer;

    localparam int BITS      = 4;
    localparam int OUT_WIDTH = 32;
    localparam int SAT_CNT_W = 16;
    localparam int SPW       = OUT_WIDTH / (2 * BITS);
    localparam int NS_W      = $clog2(SPW + 1);
    localparam int SAT_MAX   = (1 << SAT_CNT_W) - 1;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [3:0]           cfg_shift;
    logic                 cfg_round;
    logic                 sat_clr;
    logic [SAT_CNT_W-1:0] sat_cnt;
    logic [31:0]          i_tdata;
    logic                 i_tlast;
    logic                 i_tvalid;
    logic                 i_tready;
    logic [OUT_WIDTH-1:0] o_tdata;
    logic                 o_tlast;
    logic [NS_W-1:0]      o_nsamps;
    logic                 o_tvalid;
    logic                 o_tready;

    iq_sample_packer #(.BITS(BITS), .OUT_WIDTH(OUT_WIDTH), .SAT_CNT_W(SAT_CNT_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .cfg_shift (cfg_shift),
        .cfg_round (cfg_round),
        .sat_clr   (sat_clr),
        .sat_cnt   (sat_cnt),
        .i_tdata   (i_tdata),
        .i_tlast   (i_tlast),
        .i_tvalid  (i_tvalid),
        .i_tready  (i_tready),
        .o_tdata   (o_tdata),
        .o_tlast   (o_tlast),
        .o_nsamps  (o_nsamps),
        .o_tvalid  (o_tvalid),
        .o_tready  (o_tready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [OUT_WIDTH-1:0] data;
        int                   ns;
        bit                   last;
    } word_t;

    word_t exp_q[$];
    int    lanes[$];
    int    model_sat = 0;
    int    n_vec = 0;
    int    n_bad = 0;
    int    rdy_mode = 0;  // 0: always ready, 1: never ready, 2: random
    bit    clr_req = 1'b0;

    int                   n_words = 0;
    logic [OUT_WIDTH-1:0] last_data;
    int                   last_ns;
    bit                   last_last;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Floor-divide by 2^sh after optional half-up bias, then clamp to BITS signed.
    function automatic int quant(input int x, input int sh, input bit rnd, output bit sat);
        int t, d, y, hi, lo;
        t = x;
        if (rnd && sh > 0) t = t + (1 << (sh - 1));
        d = 1 << sh;
        y = t / d;
        if ((t % d) != 0 && t < 0) y = y - 1;
        hi  = (1 << (BITS - 1)) - 1;
        lo  = -(1 << (BITS - 1));
        sat = 1'b0;
        if (y > hi) begin y = hi; sat = 1'b1; end
        if (y < lo) begin y = lo; sat = 1'b1; end
        return y & ((1 << BITS) - 1);
    endfunction

    function automatic logic [OUT_WIDTH-1:0] pack_lanes();
        logic [OUT_WIDTH-1:0] w;
        w = '0;
        foreach (lanes[k]) w |= OUT_WIDTH'(lanes[k]) << (OUT_WIDTH - (k + 1) * 2 * BITS);
        return w;
    endfunction

    task automatic model_accept(input logic [15:0] iv, input logic [15:0] qv, input bit last);
        bit    si, sq;
        int    yi, yq;
        word_t w;
        yi = quant(int'($signed(iv)), int'(cfg_shift), cfg_round, si);
        yq = quant(int'($signed(qv)), int'(cfg_shift), cfg_round, sq);
        lanes.push_back((yi << BITS) | yq);
        if (clr_req) model_sat = 0;
        else if (model_sat + int'(si) + int'(sq) > SAT_MAX) model_sat = SAT_MAX;
        else model_sat = model_sat + int'(si) + int'(sq);
        if (last || lanes.size() == SPW) begin
            w.data = pack_lanes();
            w.ns   = lanes.size();
            w.last = last;
            exp_q.push_back(w);
            lanes.delete();
        end
    endtask

    function automatic bit next_rdy();
        if (rdy_mode == 0) return 1'b1;
        if (rdy_mode == 1) return 1'b0;
        return $urandom_range(0, 3) != 0;
    endfunction

    task automatic send(input logic [15:0] iv, input logic [15:0] qv, input bit last);
        int tries = 0;
        bit done = 1'b0;
        @(posedge clk);
        #2;
        i_tdata  = {iv, qv};
        i_tlast  = last;
        i_tvalid = 1'b1;
        sat_clr  = clr_req;
        o_tready = next_rdy();
        while (!done) begin
            @(negedge clk);
            if (i_tready) begin
                model_accept(iv, qv, last);
                done = 1'b1;
            end else if (tries > 500) begin
                check("send_timeout", 64'(tries), 64'd0);
                done = 1'b1;
            end else begin
                tries++;
                @(posedge clk);
                #2;
                o_tready = next_rdy();
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
            i_tvalid = 1'b0;
            i_tlast  = 1'b0;
            sat_clr  = 1'b0;
            o_tready = next_rdy();
        end
    endtask

    task automatic set_cfg(input int sh, input bit rd);
        idle(1);
        cfg_shift = 4'(sh);
        cfg_round = rd;
    endtask

    task automatic wait_words(input int target);
        int t = 0;
        while (n_words < target && t < 100) begin
            idle(1);
            t++;
        end
        check("word_count", 64'(n_words), 64'(target));
    endtask

    task automatic drain();
        int t = 0;
        rdy_mode = 0;
        while (exp_q.size() > 0 && t < 200) begin
            idle(1);
            t++;
        end
        idle(2);
        check("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    // Monitor: pops the scoreboard on each output handshake, checks hold under backpressure.
    logic [OUT_WIDTH-1:0] h_data;
    logic [NS_W-1:0]      h_ns;
    logic                 h_last;
    bit                   hold = 1'b0;

    initial begin
        word_t w;
        forever begin
            @(negedge clk);
            if (reset) begin
                hold = 1'b0;
            end else begin
                if (hold) begin
                    check("hold_data", 64'(o_tdata), 64'(h_data));
                    check("hold_nsamps", 64'(o_nsamps), 64'(h_ns));
                    check("hold_tlast", 64'(o_tlast), 64'(h_last));
                end
                if (o_tvalid && o_tready) begin
                    check("word_expected", 64'(exp_q.size() > 0), 64'd1);
                    if (exp_q.size() > 0) begin
                        w = exp_q.pop_front();
                        check("word_data", 64'(o_tdata), 64'(w.data));
                        check("word_nsamps", 64'(o_nsamps), 64'(w.ns));
                        check("word_tlast", 64'(o_tlast), 64'(w.last));
                    end
                    last_data = o_tdata;
                    last_ns   = int'(o_nsamps);
                    last_last = o_tlast;
                    n_words++;
                    hold = 1'b0;
                end else if (o_tvalid) begin
                    check("bp_i_tready", 64'(i_tready), 64'd0);
                    h_data = o_tdata;
                    h_ns   = o_nsamps;
                    h_last = o_tlast;
                    hold   = 1'b1;
                end else begin
                    hold = 1'b0;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, pos;
        bit last;
        reset     = 1'b1;
        cfg_shift = 4'd12;
        cfg_round = 1'b0;
        sat_clr   = 1'b0;
        i_tdata   = '0;
        i_tlast   = 1'b0;
        i_tvalid  = 1'b0;
        o_tready  = 1'b1;
        #1;
        check("rst_tvalid", 64'(o_tvalid), 64'd0);
        check("rst_tdata", 64'(o_tdata), 64'd0);
        check("rst_nsamps", 64'(o_nsamps), 64'd0);
        check("rst_tlast", 64'(o_tlast), 64'd0);
        check("rst_sat_cnt", 64'(sat_cnt), 64'd0);
        @(posedge clk);
        #2;
        reset = 1'b0;

        // Basic packing
        set_cfg(12, 0);
        base = n_words;
        send(16'h1000, 16'h2000, 0);
        send(16'h3000, 16'h4000, 0);
        send(16'h5000, 16'h6000, 0);
        send(16'h7000, 16'hF000, 0);
        wait_words(base + 1);
        check("basic_data", 64'(last_data), 64'h1234567F);
        check("basic_nsamps", 64'(last_ns), 64'd4);
        check("basic_tlast", 64'(last_last), 64'd0);
        idle(2);
        check("basic_sat", 64'(sat_cnt), 64'd0);

        // Partial flush, then a single-sample packet starting at lane 0
        send(16'h1000, 16'h2000, 0);
        send(16'h3000, 16'h4000, 1);
        wait_words(base + 2);
        check("partial_data", 64'(last_data), 64'h12340000);
        check("partial_nsamps", 64'(last_ns), 64'd2);
        check("partial_tlast", 64'(last_last), 64'd1);
        send(16'h1000, 16'h2000, 1);
        wait_words(base + 3);
        check("single_data", 64'(last_data), 64'h12000000);
        check("single_nsamps", 64'(last_ns), 64'd1);

        // Saturation and clear-over-increment priority
        set_cfg(8, 0);
        send(16'h7FFF, 16'h8000, 1);
        wait_words(base + 4);
        check("sat_data", 64'(last_data), 64'h78000000);
        idle(2);
        check("sat_cnt_two", 64'(sat_cnt), 64'd2);
        clr_req = 1'b1;
        send(16'h7FFF, 16'h8000, 1);
        clr_req = 1'b0;
        wait_words(base + 5);
        idle(2);
        check("sat_clr", 64'(sat_cnt), 64'd0);

        // Rounding
        set_cfg(12, 1);
        send(16'h0800, 16'h0000, 1);
        wait_words(base + 6);
        check("round_up", 64'(last_data), 64'h10000000);
        set_cfg(12, 0);
        send(16'h0800, 16'h0000, 1);
        wait_words(base + 7);
        check("round_trunc", 64'(last_data), 64'h00000000);
        set_cfg(12, 1);
        send(16'h7FFF, 16'h0000, 1);
        wait_words(base + 8);
        check("round_sat_data", 64'(last_data), 64'h70000000);
        idle(2);
        check("round_sat_cnt", 64'(sat_cnt), 64'd1);

        // Backpressure holds the formed word
        set_cfg(12, 0);
        rdy_mode = 1;
        send(16'h1000, 16'h2000, 0);
        send(16'h3000, 16'h4000, 0);
        send(16'h5000, 16'h6000, 0);
        send(16'h7000, 16'hF000, 0);
        idle(4);
        check("bp_ready_low", 64'(i_tready), 64'd0);
        check("bp_valid_high", 64'(o_tvalid), 64'd1);
        check("bp_data_held", 64'(o_tdata), 64'h1234567F);
        drain();
        check("bp_delivered", 64'(last_data), 64'h1234567F);

        // Randomized run with random o_tready
        rdy_mode = 2;
        pos = 0;
        for (int n = 0; n < 1000; n++) begin
            if (pos == 0) set_cfg($urandom_range(0, 15), 1'($urandom_range(0, 1)));
            last = ($urandom_range(0, 9) == 0) || (n == 999);
            send(16'($urandom), 16'($urandom), last);
            pos = last ? 0 : pos + 1;
        end
        drain();
        idle(2);
        check("rand_sat_cnt", 64'(sat_cnt), 64'(model_sat));

        // Asynchronous reset mid-word
        set_cfg(12, 0);
        send(16'h1000, 16'h2000, 0);
        send(16'h3000, 16'h4000, 0);
        @(posedge clk);
        #2;
        i_tvalid = 1'b0;
        #5;
        reset = 1'b1;
        #1;
        lanes.delete();
        exp_q.delete();
        model_sat = 0;
        check("arst_tvalid", 64'(o_tvalid), 64'd0);
        check("arst_tdata", 64'(o_tdata), 64'd0);
        check("arst_nsamps", 64'(o_nsamps), 64'd0);
        check("arst_tlast", 64'(o_tlast), 64'd0);
        check("arst_sat_cnt", 64'(sat_cnt), 64'd0);
        @(posedge clk);
        #2;
        reset = 1'b0;
        base = n_words;
        send(16'h5000, 16'h6000, 0);
        send(16'h7000, 16'hF000, 0);
        send(16'h1000, 16'h2000, 0);
        send(16'h3000, 16'h4000, 0);
        wait_words(base + 1);
        check("arst_word", 64'(last_data), 64'h567F1234);
        check("arst_nsamps_after", 64'(last_ns), 64'd4);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/iq_sample_packer.md
Name: iq_sample_packer

Overview:
- Parametrised IQ sample compressor for the QPSK RFNoC datapath.
- Accepts 16-bit I / 16-bit Q complex samples on an AXI-Stream slave.
- Quantises each component to BITS signed bits using a runtime-selectable shift, optional rounding and saturation.
- Packs SPW = OUT_WIDTH/(2*BITS) samples per output word, with packet-aware flushing on tlast.
- Sits between the baseband filter chain and the radio/host transport, replacing the fixed 4-bit keep-one-in-four packer.

Parameters:
- BITS, 4, bits per I or Q component after quantisation; legal values 1, 2, 4, 8.
- OUT_WIDTH, 32, output word width; must be a multiple of 2*BITS.
- SAT_CNT_W, 16, width of the saturation event counter.

Ports:
- clk, input, 1, clock.
- reset, input, 1, asynchronous, active-high reset.
- cfg_shift, input, 4, arithmetic right shift applied before saturation (0..15).
- cfg_round, input, 1, 1 = round half-up before the shift; 0 = truncate.
- sat_clr, input, 1, synchronous clear of sat_cnt.
- sat_cnt, output, SAT_CNT_W, count of saturated components; sticks at all-ones.
- i_tdata, input, 32, sample: [31:16] = I, [15:0] = Q, two's complement.
- i_tlast, input, 1, last sample of packet.
- i_tvalid, input, 1, AXI-S valid.
- i_tready, output, 1, AXI-S ready.
- o_tdata, output, OUT_WIDTH, packed word.
- o_tlast, output, 1, last word of packet.
- o_nsamps, output, clog2(SPW+1), number of valid lanes in o_tdata (1..SPW).
- o_tvalid, output, 1, AXI-S valid.
- o_tready, input, 1, AXI-S ready.

Behaviour:
- Reset: asynchronous, active-high. Clears o_tdata, o_tlast, o_nsamps, o_tvalid, sat_cnt, the lane counter and the accumulator to 0.
- Quantiser, per component x (16-bit signed):
  - If cfg_round = 1 and cfg_shift > 0, compute t = x + 2^(cfg_shift-1) in 17-bit signed; otherwise t = x.
  - y = t >>> cfg_shift.
  - Clamp y to [-2^(BITS-1), 2^(BITS-1)-1] and keep the BITS LSBs.
  - Clamping counts as one saturation event per component.
- Lane packing:
  - Lane k (0 = first sample of word) occupies o_tdata[OUT_WIDTH-1-k*2*BITS -: 2*BITS] as {Iq, Qq}.
  - Unused lanes in a partial word are 0.
- Accept = i_tvalid & i_tready. On each accept, the quantised sample is written into accumulator lane lane_cnt.
- Word completion on accept occurs when lane_cnt == SPW-1 or i_tlast == 1. On completion:
  - o_tdata is loaded with the accumulator contents including the current sample.
  - o_nsamps is loaded with lane_cnt+1.
  - o_tlast is loaded with i_tlast.
  - o_tvalid is set.
  - lane_cnt and the accumulator clear to 0.
- On a non-completing accept, lane_cnt increments.
- Latency: o_tvalid rises one clk after the completing accept.
- Handshake:
  - i_tready = ~o_tvalid | o_tready (registered output stage with bypass-on-drain).
  - o_tvalid clears on o_tready unless a new completion occurs in the same cycle; in that case the register reloads and o_tvalid stays 1.
  - Full throughput of 1 sample/clk is sustained while o_tready = 1.
- Backpressure: while o_tvalid & ~o_tready, i_tready = 0 and o_tdata, o_tlast, o_nsamps hold stable.
- Configuration: cfg_shift and cfg_round are sampled per accepted sample, so a change takes effect on the next accepted sample. Software changes them only between packets.
- sat_cnt:
  - Adds 0, 1 or 2 per accepted sample, saturating at 2^SAT_CNT_W-1.
  - sat_clr has priority over an increment in the same cycle; the result is 0.
- A single-sample packet (tlast on lane 0) yields one word with o_nsamps = 1.
- Reset mid-word discards the partial accumulator and any pending output word; no word is emitted for it.

Decomposition:
- Package iq_pack_pkg holds:
  - IQ_W = 16 constant.
  - Function spw(BITS, OUT_WIDTH).
  - Quantise function signature and the legal-BITS check used by an elaboration-time assertion.
- Sub-module iq_quantizer (combinational, one per component, instantiated twice):
  - Inputs: x, cfg_shift, cfg_round.
  - Outputs: y[BITS-1:0] and sat flag.
- The top level holds the lane counter, accumulator, output register and sat counter.

Test Plan:
- Basic packing: BITS=4, shift=12, round=0, o_tready=1. Input samples (I,Q) = (0x1000,0x2000), (0x3000,0x4000), (0x5000,0x6000), (0x7000,0xF000) -> one word 0x1234567F, o_nsamps=4, o_tlast=0, sat_cnt=0.
- Partial flush: same config, 2 samples (0x1000,0x2000), (0x3000,0x4000) with tlast on the 2nd -> 0x12340000, o_tlast=1, o_nsamps=2. The next sample lands in lane 0.
- Saturation: shift=8, sample (0x7FFF,0x8000) -> lane value 0x78 (7 and -8), sat_cnt increments by 2. A sat_clr pulse concurrent with another saturating accept -> sat_cnt=0.
- Rounding: shift=12, sample I=0x0800 -> round=1 gives 0x1, round=0 gives 0x0. I=0x7FFF with round=1 -> saturates to 0x7, sat event counted.
- Backpressure: hold o_tready=0 after a word is formed -> o_tdata stable, i_tready=0, no samples lost or duplicated. A random o_tready stream over 1000 samples matches the reference-model word sequence exactly.
- Async reset: assert reset after 2 accepted samples, mid-clock -> all outputs 0 immediately. After release, 4 new samples produce exactly one word containing only those samples.
